// File: rtl/sata_cont_encoder.sv
// sata_cont_encoder: transmit-side CONT suppression for the SATA link layer.
// A run of identical primitives is sent verbatim NREPEAT times, then CONT,
// then scrambled junk dwords until the primitive stream changes. There is one
// output register stage, and o_ready stalls the whole block.
module sata_cont_encoder #(
    parameter int unsigned NREPEAT      = 2,
    parameter bit          ALIGN_BYPASS = 1'b1,
    parameter int unsigned CNTWIDTH     = 16,
    // Bit k-1 set means term x^k is present (x^0 implied):
    // 16'hD008 = x^16 + x^15 + x^13 + x^4 + 1
    parameter logic [15:0] LFSR_POLY    = 16'hD008,
    parameter logic [47:0] LFSR_INIT    = 48'hC3A5_5A3C_FFFF,
    parameter logic [31:0] ALIGN_PRIM   = 32'h7B4A_4ABC,
    parameter logic [31:0] CONT_PRIM    = 32'h9999_AA7C
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic                clr_cnt,
    input  logic [31:0]         i_data,
    input  logic                i_datak,
    output logic                i_ready,
    output logic [31:0]         o_data,
    output logic                o_datak,
    input  logic                o_ready,
    output logic [CNTWIDTH-1:0] cont_cnt
);

    localparam logic K_PRIM = 1'b1;
    localparam logic K_DATA = 1'b0;
    localparam int   RCW    = $clog2(NREPEAT + 1);
    localparam logic [RCW-1:0] RMAX = RCW'(NREPEAT);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_CONT,
        ST_JUNK
    } state_t;

    state_t             state_q;
    logic [RCW-1:0]     rcnt_q;
    logic [31:0]        last_q;
    logic               last_vld_q;
    logic [31:0]        o_data_q;
    logic               o_datak_q;
    logic [CNTWIDTH-1:0] cont_cnt_q;
    logic [CNTWIDTH-1:0] cont_cnt_d;
    logic [47:0]        lfsr_q;
    logic [47:0]        lfsr_d;
    logic [31:0]        junk_word;

    logic accept;
    logic is_align;
    logic is_repeat;
    logic start_run;
    logic cont_emit;
    logic junk_emit;

    assign i_ready  = o_ready;
    assign o_data   = o_data_q;
    assign o_datak  = o_datak_q;
    assign cont_cnt = cont_cnt_q;

    // Classify the incoming word against the current run.
    always_comb begin
        accept    = o_ready;
        // ALIGN is only transparent while suppression is active; with ena low
        // every word is plain pass-through and simply clears the run.
        is_align  = ALIGN_BYPASS && ena && (i_datak == K_PRIM) && (i_data == ALIGN_PRIM);
        is_repeat = ena && (i_datak == K_PRIM) && last_vld_q && (i_data == last_q) && !is_align;
        start_run = ena && (i_datak == K_PRIM);
        cont_emit = accept && is_repeat && (state_q == ST_PASS) && (rcnt_q == RMAX);
        junk_emit = accept && is_repeat && (state_q != ST_PASS);
    end

    // Advance the 48-bit history register by 32 bits of the degree-16 sequence.
    // Bit 0 holds the newest bit, so bit k-1 is the bit emitted k steps ago.
    always_comb begin
        lfsr_d = lfsr_q;
        for (int s = 0; s < 32; s++) begin
            lfsr_d = {lfsr_d[46:0], ^(lfsr_d[15:0] & LFSR_POLY)};
        end
    end

    // Junk dword is the upper 32 history bits, bit-reversed.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
        assign junk_word[gi] = lfsr_q[47-gi];
    end

    // Saturating CONT counter next value; clear beats increment.
    always_comb begin
        cont_cnt_d = cont_cnt_q;
        if (clr_cnt) begin
            cont_cnt_d = '0;
        end else if (cont_emit && (cont_cnt_q != {CNTWIDTH{1'b1}})) begin
            cont_cnt_d = cont_cnt_q + CNTWIDTH'(1);
        end
    end

    // Suppression FSM with registered output dword.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PASS;
            rcnt_q     <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            o_data_q   <= '0;
            o_datak_q  <= K_DATA;
        end else if (accept) begin
            if (is_align) begin
                // Transparent: run state untouched so suppression resumes.
                o_data_q  <= i_data;
                o_datak_q <= i_datak;
            end else if (is_repeat) begin
                if (state_q == ST_PASS) begin
                    if (rcnt_q == RMAX) begin
                        o_data_q  <= CONT_PRIM;
                        o_datak_q <= K_PRIM;
                        state_q   <= ST_CONT;
                    end else begin
                        o_data_q  <= i_data;
                        o_datak_q <= i_datak;
                        rcnt_q    <= rcnt_q + RCW'(1);
                    end
                end else begin
                    o_data_q  <= junk_word;
                    o_datak_q <= K_DATA;
                    state_q   <= ST_JUNK;
                end
            end else begin
                // Any change in the stream ends the run; a primitive starts a new one.
                o_data_q   <= i_data;
                o_datak_q  <= i_datak;
                state_q    <= ST_PASS;
                last_q     <= i_data;
                last_vld_q <= start_run;
                rcnt_q     <= start_run ? RCW'(1) : '0;
            end
        end
    end

    // Junk generator only moves when a junk dword is actually sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_INIT;
        end else if (junk_emit) begin
            lfsr_q <= lfsr_d;
        end
    end

    // CONT statistics counter; clear works even while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_cnt_q <= '0;
        end else begin
            cont_cnt_q <= cont_cnt_d;
        end
    end

endmodule
